da_wave_gen: RTL and testbench
==============================

Name: da_wave_gen

Overview:
- Waveform sample source that sits directly upstream of the DA send stage. It replaces the fixed waveform ROM.
- Takes the 8-bit read address driven by the send stage and returns one 8-bit sample per clock with registered, ROM-equivalent 1-cycle latency.
- Synthesises sine (quarter-wave table), square, triangle and sawtooth.
- Amplitude is selectable; waveform/amplitude changes apply only at the period boundary (address 0), so no glitches appear mid-period.

Parameters:
- MID_CODE, 8'd128, DA mid-scale code driven while in reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rd_addr  input  8  sample address (phase) from the send stage.
- wave_sel  input  2  requested waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- amp_sel  input  2  requested attenuation: 0 full, 1 half, 2 quarter, 3 eighth.
- rd_data  output  8  registered sample for the address presented on the previous cycle.
- frame_start  output  1  1-cycle pulse aligned with rd_data for address 0.
- cur_wave  output  2  waveform currently in effect (latched).

Behaviour:
- Reset (rst_n=0 at a rising edge): rd_data=MID_CODE, frame_start=0, cur_wave=0, internal cur_amp=0. Reset dominates all other activity, including mid-period.
- Latency: rd_data and frame_start update on the edge after rd_addr is sampled, exactly 1 cycle. The same address held for N cycles produces the same rd_data for N cycles.
- Selection latching: eff_wave=(rd_addr==0)?wave_sel:cur_wave and eff_amp=(rd_addr==0)?amp_sel:cur_amp. Both are used for the sample computed that cycle. On an edge with rd_addr==0, cur_wave<=wave_sel and cur_amp<=amp_sel. Otherwise they hold.
- Changes to wave_sel/amp_sel while rd_addr!=0 have no effect until the next address-0 cycle.
- frame_start<=(rd_addr==0) every cycle. If the address is held at 0 for several cycles, frame_start stays high for those cycles.
- Raw value v, with a=rd_addr, q=a[7:6], i=a[5:0]:
  - Sine: Q[k]=round(127*sin(pi*(2k+1)/256)), k=0..63, a 64x7-bit constant table (Q[0]=2, Q[63]=127).
    - q=0: 128+Q[i]
    - q=1: 128+Q[63-i]
    - q=2: 127-Q[i]
    - q=3: 127-Q[63-i]
  - Square: a[7]==0 ? 255 : 0.
  - Triangle: a[7]==0 ? {a[6:0],0} : 255-{a[6:0],0}.
  - Sawtooth: v=a.
- Attenuation (unsigned, 8-bit, no overflow possible):
  - amp 0: v
  - amp 1: (v>>1)+64
  - amp 2: (v>>2)+96
  - amp 3: (v>>3)+112
- rd_data<=attenuated v. There is no other pipeline stage; table lookup and scaling are combinational ahead of the output register.
- Wrap-around: address 255→0 is the natural period boundary. No special handling beyond latching.
- cur_wave reflects the latched value, updated on the same edge as the address-0 sample.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with arbitrary rd_addr → rd_data=128, frame_start=0, cur_wave=0. Release with wave_sel=0, amp_sel=0, rd_addr=0 → next cycle rd_data=130, frame_start=1.
- Sine sweep: wave 0, amp 0, addr 0..255 incrementing each cycle → one cycle later: addr 0→130, 63→255, 64→255, 128→125, 192→0, 255→125. All 256 values match the formula.
- Other shapes, amp 0:
  - square: addr 127→255, 128→0.
  - triangle: addr 0→0, 127→254, 128→255, 255→1.
  - sawtooth: rd_data equals the previous-cycle addr.
- Deferred switch: during the sine sweep, set wave_sel=1 at addr 50 → addr 51..255 still sine, cur_wave stays 0. At addr 0, rd_data=255 (square) and cur_wave=1 on the same edge.
- Attenuation, square at the boundary:
  - amp 1: 191 / 64.
  - amp 2: 159 / 96.
  - amp 3: 143 / 112.
  - amp_sel changed mid-period takes effect only after the next address 0.
- Mid-operation reset: assert rst_n=0 at addr 100 of a triangle → rd_data=128 next edge, cur_wave=0. After release, sine output is produced even if wave_sel is still 2, until the next address 0 latches it.
- Send-stage integration: addr held 6 cycles per step → rd_data constant over each 6-cycle hold.

Source files
------------

// File: rtl/da_wave_gen.sv
// da_wave_gen: synthesised DA waveform source, a drop-in ROM replacement.
// Ports: clk, rst_n (sync, active-low), rd_addr[7:0] phase, wave_sel[1:0]
//   (sine/square/tri/saw), amp_sel[1:0] (1,1/2,1/4,1/8 about mid-scale),
//   rd_data[7:0] registered sample, frame_start (addr-0 marker), cur_wave[1:0].
module da_wave_gen #(
  parameter logic [7:0] MID_CODE = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rd_addr,
  input  logic [1:0] wave_sel,
  input  logic [1:0] amp_sel,
  output logic [7:0] rd_data,
  output logic       frame_start,
  output logic [1:0] cur_wave
);

  logic [7:0] data_q, data_d;
  logic       fs_q, fs_d;
  logic [1:0] wave_q, wave_d;
  logic [1:0] amp_q, amp_d;

  logic       at_zero;
  logic [1:0] eff_wave;
  logic [1:0] eff_amp;
  logic [5:0] q_idx;
  logic [6:0] q_val;
  logic [7:0] tri_up;
  logic [7:0] raw;

  // Quarter-wave sine magnitude, round(127*sin(pi*(2k+1)/256)).
  function automatic logic [6:0] sine_q(input logic [5:0] k);
    logic [6:0] q;
    case (k)
      6'd0:  q = 7'd2;
      6'd1:  q = 7'd5;
      6'd2:  q = 7'd8;
      6'd3:  q = 7'd11;
      6'd4:  q = 7'd14;
      6'd5:  q = 7'd17;
      6'd6:  q = 7'd20;
      6'd7:  q = 7'd23;
      6'd8:  q = 7'd26;
      6'd9:  q = 7'd29;
      6'd10: q = 7'd32;
      6'd11: q = 7'd35;
      6'd12: q = 7'd38;
      6'd13: q = 7'd41;
      6'd14: q = 7'd44;
      6'd15: q = 7'd47;
      6'd16: q = 7'd50;
      6'd17: q = 7'd53;
      6'd18: q = 7'd56;
      6'd19: q = 7'd58;
      6'd20: q = 7'd61;
      6'd21: q = 7'd64;
      6'd22: q = 7'd67;
      6'd23: q = 7'd69;
      6'd24: q = 7'd72;
      6'd25: q = 7'd74;
      6'd26: q = 7'd77;
      6'd27: q = 7'd79;
      6'd28: q = 7'd82;
      6'd29: q = 7'd84;
      6'd30: q = 7'd86;
      6'd31: q = 7'd89;
      6'd32: q = 7'd91;
      6'd33: q = 7'd93;
      6'd34: q = 7'd95;
      6'd35: q = 7'd97;
      6'd36: q = 7'd99;
      6'd37: q = 7'd101;
      6'd38: q = 7'd103;
      6'd39: q = 7'd105;
      6'd40: q = 7'd106;
      6'd41: q = 7'd108;
      6'd42: q = 7'd110;
      6'd43: q = 7'd111;
      6'd44: q = 7'd113;
      6'd45: q = 7'd114;
      6'd46: q = 7'd115;
      6'd47: q = 7'd117;
      6'd48: q = 7'd118;
      6'd49: q = 7'd119;
      6'd50: q = 7'd120;
      6'd51: q = 7'd121;
      6'd52: q = 7'd122;
      6'd53: q = 7'd123;
      6'd54: q = 7'd124;
      6'd55: q = 7'd124;
      6'd56: q = 7'd125;
      6'd57: q = 7'd125;
      6'd58: q = 7'd126;
      6'd59: q = 7'd126;
      6'd60: q = 7'd127;
      6'd61: q = 7'd127;
      6'd62: q = 7'd127;
      6'd63: q = 7'd127;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  // New selections are honoured only on the address-0 sample itself.
  assign at_zero  = (rd_addr == 8'd0);
  assign eff_wave = at_zero ? wave_sel : wave_q;
  assign eff_amp  = at_zero ? amp_sel : amp_q;

  // Odd quarters run the table backwards (63-i == ~i for 6 bits).
  assign q_idx  = rd_addr[6] ? ~rd_addr[5:0] : rd_addr[5:0];
  assign q_val  = sine_q(q_idx);
  assign tri_up = {rd_addr[6:0], 1'b0};

  always_comb begin
    raw = rd_addr;
    unique case (eff_wave)
      2'd0: raw = rd_addr[7] ? (8'd127 - {1'b0, q_val})
                             : (8'd128 + {1'b0, q_val});
      2'd1: raw = rd_addr[7] ? 8'd0 : 8'd255;
      2'd2: raw = rd_addr[7] ? (8'd255 - tri_up) : tri_up;
      2'd3: raw = rd_addr;
      default: raw = rd_addr;
    endcase
  end

  // Attenuation shrinks the swing about mid-scale.
  always_comb begin
    data_d = raw;
    unique case (eff_amp)
      2'd0: data_d = raw;
      2'd1: data_d = (raw >> 1) + 8'd64;
      2'd2: data_d = (raw >> 2) + 8'd96;
      2'd3: data_d = (raw >> 3) + 8'd112;
      default: data_d = raw;
    endcase
  end

  assign fs_d   = at_zero;
  assign wave_d = eff_wave;
  assign amp_d  = eff_amp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= MID_CODE;
      fs_q   <= 1'b0;
      wave_q <= 2'd0;
      amp_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      fs_q   <= fs_d;
      wave_q <= wave_d;
      amp_q  <= amp_d;
    end
  end

  assign rd_data     = data_q;
  assign frame_start = fs_q;
  assign cur_wave    = wave_q;

endmodule

// File: tb/tb_da_wave_gen.sv
// tb_da_wave_gen: vector table, directed sequences and random traffic
// for da_wave_gen against an arithmetic waveform model.
module tb_da_wave_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] rd_addr;
  logic [1:0] wave_sel;
  logic [1:0] amp_sel;
  logic [7:0] rd_data;
  logic       frame_start;
  logic [1:0] cur_wave;

  da_wave_gen #(.MID_CODE(8'd128)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr(rd_addr),
    .wave_sel(wave_sel),
    .amp_sel(amp_sel),
    .rd_data(rd_data),
    .frame_start(frame_start),
    .cur_wave(cur_wave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int qtab[64];
  logic [7:0] exp_data;
  logic       exp_fs;
  logic [1:0] m_wave;
  logic [1:0] m_amp;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] wave;
    logic [1:0] amp;
    logic [7:0] expv;
  } vec_t;

  vec_t vt[20];

  function automatic logic [7:0] ref_sample(int a, int w, int amp);
    int v;
    int q;
    int i;
    logic [7:0] r;
    q = a / 64;
    i = a % 64;
    case (w)
      0: begin
        case (q)
          0: v = 128 + qtab[i];
          1: v = 128 + qtab[63 - i];
          2: v = 127 - qtab[i];
          default: v = 127 - qtab[63 - i];
        endcase
      end
      1: v = (a < 128) ? 255 : 0;
      2: v = (a < 128) ? 2 * (a % 128) : 255 - 2 * (a % 128);
      default: v = a;
    endcase
    if (amp != 0) v = v / (2 ** amp) + 128 - 128 / (2 ** amp);
    r = v[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_data"}, rd_data, exp_data);
    chk({nm, "_fs"}, {7'd0, frame_start}, {7'd0, exp_fs});
    chk({nm, "_wave"}, {6'd0, cur_wave}, {6'd0, m_wave});
  endtask

  // One clock: drive, clock, update model, settle.
  task automatic cycle(input int a, input int w, input int amp,
                       input logic r);
    logic [1:0] ew;
    logic [1:0] ea;
    rd_addr  = a[7:0];
    wave_sel = w[1:0];
    amp_sel  = amp[1:0];
    rst_n    = r;
    @(posedge clk);
    if (!r) begin
      exp_data = 8'd128;
      exp_fs   = 1'b0;
      m_wave   = 2'd0;
      m_amp    = 2'd0;
    end else begin
      ew = (a == 0) ? w[1:0] : m_wave;
      ea = (a == 0) ? amp[1:0] : m_amp;
      exp_data = ref_sample(a, ew, ea);
      exp_fs   = (a == 0);
      m_wave   = ew;
      m_amp    = ea;
    end
    #1;
  endtask

  initial begin
    int a;
    int ph;
    rst_n    = 1'b0;
    rd_addr  = 8'd0;
    wave_sel = 2'd0;
    amp_sel  = 2'd0;
    exp_data = 8'd128;
    exp_fs   = 1'b0;
    m_wave   = 2'd0;
    m_amp    = 2'd0;
    for (int k = 0; k < 64; k++)
      qtab[k] = $rtoi(127.0 * $sin(3.14159265358979 * (2 * k + 1) / 256.0)
                      + 0.5);

    vt = '{
      '{8'd0,   2'd0, 2'd0, 8'd130},
      '{8'd63,  2'd0, 2'd0, 8'd255},
      '{8'd64,  2'd0, 2'd0, 8'd255},
      '{8'd128, 2'd0, 2'd0, 8'd125},
      '{8'd192, 2'd0, 2'd0, 8'd0},
      '{8'd255, 2'd0, 2'd0, 8'd125},
      '{8'd127, 2'd1, 2'd0, 8'd255},
      '{8'd128, 2'd1, 2'd0, 8'd0},
      '{8'd0,   2'd2, 2'd0, 8'd0},
      '{8'd127, 2'd2, 2'd0, 8'd254},
      '{8'd128, 2'd2, 2'd0, 8'd255},
      '{8'd255, 2'd2, 2'd0, 8'd1},
      '{8'd77,  2'd3, 2'd0, 8'd77},
      '{8'd0,   2'd1, 2'd1, 8'd191},
      '{8'd128, 2'd1, 2'd1, 8'd64},
      '{8'd0,   2'd1, 2'd2, 8'd159},
      '{8'd128, 2'd1, 2'd2, 8'd96},
      '{8'd0,   2'd1, 2'd3, 8'd143},
      '{8'd128, 2'd1, 2'd3, 8'd112},
      '{8'd192, 2'd0, 2'd1, 8'd64}
    };

    // Reset with arbitrary addresses.
    for (int k = 0; k < 3; k++) begin
      cycle($urandom_range(0, 255), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'b0);
      chk("rst_data", rd_data, 8'd128);
      chk("rst_fs", {7'd0, frame_start}, 8'd0);
      chk("rst_wave", {6'd0, cur_wave}, 8'd0);
    end
    cycle(0, 0, 0, 1'b1);
    chk("rel_data", rd_data, 8'd130);
    chk("rel_fs", {7'd0, frame_start}, 8'd1);

    // Vector table: latch selection at address 0, then probe.
    for (int k = 0; k < 20; k++) begin
      cycle(0, vt[k].wave, vt[k].amp, 1'b1);
      cycle(vt[k].addr, vt[k].wave, vt[k].amp, 1'b1);
      chk($sformatf("vec%0d", k), rd_data, vt[k].expv);
      chk_model($sformatf("vecm%0d", k));
    end

    // Sine sweep with a deferred switch to square.
    for (int k = 0; k < 256; k++) begin
      cycle(k, (k >= 50) ? 1 : 0, 0, 1'b1);
      chk_model("sweep");
      if (k > 50) chk("sweep_wave", {6'd0, cur_wave}, 8'd0);
    end
    cycle(0, 1, 0, 1'b1);
    chk("switch_data", rd_data, 8'd255);
    chk("switch_wave", {6'd0, cur_wave}, 8'd1);

    // Sawtooth echoes the previous address.
    cycle(0, 3, 0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(1, 255);
      cycle(a, 3, 0, 1'b1);
      chk("saw_echo", rd_data, a[7:0]);
    end

    // Amplitude change mid-period is deferred.
    cycle(0, 1, 0, 1'b1);
    chk("amp_pre", rd_data, 8'd255);
    for (int k = 1; k <= 100; k++) begin
      cycle(k, 1, (k >= 10) ? 3 : 0, 1'b1);
      chk_model("amp_mid");
    end
    chk("amp_hold", rd_data, 8'd255);
    cycle(0, 1, 3, 1'b1);
    chk("amp_apply", rd_data, 8'd143);

    // Reset in the middle of a triangle period.
    cycle(0, 2, 0, 1'b1);
    for (int k = 1; k < 100; k++) begin
      cycle(k, 2, 0, 1'b1);
      chk_model("tri_run");
    end
    cycle(100, 2, 0, 1'b0);
    chk("mrst_data", rd_data, 8'd128);
    chk("mrst_wave", {6'd0, cur_wave}, 8'd0);
    cycle(101, 2, 0, 1'b1);
    chk("post_rst_sine", rd_data, 8'd205);
    for (int k = 102; k < 256; k++) begin
      cycle(k, 2, 0, 1'b1);
      chk_model("post_rst");
    end
    cycle(0, 2, 0, 1'b1);
    chk("relatch_data", rd_data, 8'd0);
    chk("relatch_wave", {6'd0, cur_wave}, 8'd2);

    // Send-stage style: each address held for six cycles.
    cycle(0, 0, 1, 1'b1);
    for (int s = 1; s <= 20; s++) begin
      for (int h = 0; h < 6; h++) begin
        cycle(s * 12, 0, 1, 1'b1);
        chk_model("hold");
      end
    end

    // Random traffic: mostly a running phase with jumps and resets.
    ph = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) ph = $urandom_range(0, 255);
      else ph = (ph + 1) % 256;
      cycle(ph, $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 99) != 0));
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
